// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory access unit for the 5-stage MIPS pipeline.
//
// Runs one handshaked word-bus transaction per load/store held in EX/MEM, aligns and
// extends load data into ReadDataFromMem_MEM, and stalls upstream stages while busy.
//
// Optional feature macro: MEM_TIMEOUT_EN (abort a WAIT after TIMEOUT_CYCLES with BusErr_MEM).
//
// Ports:
//   Clk, Reset                 clock (rising edge), asynchronous active-high reset
//   MemRead_MEM, MemWrite_MEM  load / store request (store wins if both set)
//   MemSize_MEM                00 byte, 01 half, 1x word
//   MemSignExt_MEM             sign-extend byte/half loads when set
//   ALUResult_MEM              byte address
//   WriteData_MEM              right-justified store data
//   ReadDataFromMem_MEM        registered aligned/extended load result
//   Stall_MEM                  combinational upstream hold
//   MisalignExc_MEM            combinational misaligned-access pulse
//   BusErr_MEM                 registered timeout pulse (0 without MEM_TIMEOUT_EN)
//   MemReq/MemWe/MemAddr/MemWData/MemBe  registered bus request side
//   MemAck, MemRData           bus completion and read data
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MemRead_MEM,
  input  logic        MemWrite_MEM,
  input  logic [1:0]  MemSize_MEM,
  input  logic        MemSignExt_MEM,
  input  logic [31:0] ALUResult_MEM,
  input  logic [31:0] WriteData_MEM,
  output logic [31:0] ReadDataFromMem_MEM,
  output logic        Stall_MEM,
  output logic        MisalignExc_MEM,
  output logic        BusErr_MEM,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic [3:0]  MemBe,
  input  logic        MemAck,
  input  logic [31:0] MemRData
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e r_state, w_state_next;

  logic        w_op;
  logic        w_misalign;
  logic        w_accept;
  logic        w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  // Access attributes latched at accept time; the EX/MEM inputs are frozen anyway,
  // but keeping a private copy makes the extraction independent of upstream behaviour.
  logic        r_is_load;
  logic [1:0]  r_size;
  logic        r_sext;
  logic [1:0]  r_lane;

  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_be;
  logic [31:0] r_rdata;

  assign w_op = MemRead_MEM | MemWrite_MEM;

  // Bytes are never misaligned; halves need addr[0]=0; words need addr[1:0]=00.
  assign w_misalign = (MemSize_MEM == 2'b00) ? 1'b0 :
                      (MemSize_MEM == 2'b01) ? ALUResult_MEM[0] :
                      (|ALUResult_MEM[1:0]);

  // Store lane steering: replicate the right-justified data across all lanes.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = WriteData_MEM;
    case (MemSize_MEM)
      2'b00: begin
        w_be    = 4'b0001 << ALUResult_MEM[1:0];
        w_wdata = {4{WriteData_MEM[7:0]}};
      end
      2'b01: begin
        w_be    = ALUResult_MEM[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{WriteData_MEM[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = WriteData_MEM;
      end
    endcase
  end

  // Load lane extraction from the bus word, using the latched access attributes.
  always_comb begin
    w_byte      = MemRData[7:0];
    w_half      = r_lane[1] ? MemRData[31:16] : MemRData[15:0];
    w_load_data = MemRData;
    case (r_lane)
      2'b00:   w_byte = MemRData[7:0];
      2'b01:   w_byte = MemRData[15:8];
      2'b10:   w_byte = MemRData[23:16];
      default: w_byte = MemRData[31:24];
    endcase
    case (r_size)
      2'b00:   w_load_data = {{24{r_sext & w_byte[7]}}, w_byte};
      2'b01:   w_load_data = {{16{r_sext & w_half[15]}}, w_half};
      default: w_load_data = MemRData;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CntW-1:0] r_tmo_cnt;
  logic            r_bus_err;

  // Fires in the TIMEOUT_CYCLES-th WAIT cycle; an ack in that same cycle takes precedence.
  assign w_timeout = (r_state == StWait) && !MemAck &&
                     (r_tmo_cnt == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_tmo_cnt <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_bus_err <= w_timeout;
      if (w_accept) begin
        r_tmo_cnt <= '0;
      end else if (r_state == StWait) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
    end
  end

  assign BusErr_MEM = r_bus_err;
`else
  logic w_unused_tmo;

  assign w_unused_tmo = ^TIMEOUT_CYCLES;
  assign w_timeout    = 1'b0;
  assign BusErr_MEM   = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    Stall_MEM       = 1'b0;
    MisalignExc_MEM = 1'b0;
    w_accept        = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_op) begin
          if (w_misalign) begin
            MisalignExc_MEM = 1'b1;
          end else begin
            w_accept     = 1'b1;
            Stall_MEM    = 1'b1;
            w_state_next = StWait;
          end
        end
      end
      StWait: begin
        Stall_MEM = 1'b1;
        if (MemAck || w_timeout) begin
          w_state_next = StDone;
        end
      end
      // Stall is released here so MEM/WB captures the result; no new op is taken.
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= 4'b0000;
      r_rdata     <= '0;
      r_is_load   <= 1'b0;
      r_size      <= 2'b00;
      r_sext      <= 1'b0;
      r_lane      <= 2'b00;
    end else begin
      if (w_accept) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= MemWrite_MEM;
        r_mem_addr  <= {ALUResult_MEM[31:2], 2'b00};
        r_mem_wdata <= w_wdata;
        r_mem_be    <= w_be;
        r_is_load   <= ~MemWrite_MEM;
        r_size      <= MemSize_MEM;
        r_sext      <= MemSignExt_MEM;
        r_lane      <= ALUResult_MEM[1:0];
      end else if (MisalignExc_MEM) begin
        r_rdata <= '0;
      end

      if ((r_state == StWait) && MemAck) begin
        r_mem_req <= 1'b0;
        r_rdata   <= r_is_load ? w_load_data : 32'h0;
      end else if (w_timeout) begin
        r_mem_req <= 1'b0;
        r_rdata   <= '0;
      end
    end
  end

  assign MemReq              = r_mem_req;
  assign MemWe               = r_mem_we;
  assign MemAddr             = r_mem_addr;
  assign MemWData            = r_mem_wdata;
  assign MemBe               = r_mem_be;
  assign ReadDataFromMem_MEM = r_rdata;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Data-memory access unit for the MEM stage of the 5-stage MIPS pipeline. It takes the load/store controls, address and store data held in the EX/MEM pipeline register and runs one handshaked transaction per load/store on a word-wide data-memory bus. It aligns and extends load data into `ReadDataFromMem_MEM`, which the MEM/WB register captures. While a transaction is outstanding it raises `Stall_MEM` to freeze the upstream stages.

## Interface
- `TIMEOUT_CYCLES`, default 16: maximum WAIT cycles before abort. Only used with `MEM_TIMEOUT_EN`.
- `Clk` in 1: pipeline clock, rising edge.
- `Reset` in 1: asynchronous, active-high. Clears FSM and all registered outputs.
- `MemRead_MEM` in 1: load request.
- `MemWrite_MEM` in 1: store request. Takes priority if both requests are high.
- `MemSize_MEM` in 2: access size. 00 = byte, 01 = half, 10 = word, 11 = word.
- `MemSignExt_MEM` in 1: 1 = sign-extend byte/half loads, 0 = zero-extend.
- `ALUResult_MEM` in 32: byte address.
- `WriteData_MEM` in 32: store data, right-justified.
- `ReadDataFromMem_MEM` out 32: aligned/extended load result. Registered.
- `Stall_MEM` out 1: hold EX/MEM and earlier stages. Combinational.
- `MisalignExc_MEM` out 1: one-cycle pulse on a misaligned access. Combinational.
- `BusErr_MEM` out 1: one-cycle timeout pulse. Registered. Tied 0 without `MEM_TIMEOUT_EN`.
- `MemReq` out 1: bus request. Registered.
- `MemWe` out 1: bus write enable. Registered.
- `MemAddr` out 32: word address, bits [1:0] = 00. Registered.
- `MemWData` out 32: lane-replicated store data. Registered.
- `MemBe` out 4: byte enables. Registered.
- `MemAck` in 1: bus completion, sampled on rising edge.
- `MemRData` in 32: bus read data, valid when `MemAck` = 1.

## Operation
- FSM states: IDLE, WAIT, DONE. Reset state is IDLE.
- op = `MemRead_MEM` | `MemWrite_MEM`.
- Misaligned access: half with addr[0] = 1, or word with addr[1:0] ≠ 00.
- IDLE:
  - op and aligned: register the bus outputs, set `MemReq` = 1, go to WAIT. `Stall_MEM` = 1 this cycle.
  - op and misaligned: no bus access, `MisalignExc_MEM` = 1, `Stall_MEM` = 0, `ReadDataFromMem_MEM` loaded with 0, stay in IDLE.
  - No op: nothing happens.
- WAIT:
  - `Stall_MEM` = 1.
  - `MemReq`, `MemWe`, `MemAddr`, `MemWData`, `MemBe` are held constant.
  - On `MemAck` = 1: drop `MemReq`. For a load, capture the extracted data into `ReadDataFromMem_MEM`; for a store, load 0. Go to DONE.
- DONE:
  - `Stall_MEM` = 0, so MEM/WB captures the result at the end of this cycle.
  - Unconditionally return to IDLE; a new op is not accepted in DONE.
- Byte lanes are little-endian; k = addr[1:0].
  - Byte: `MemBe` = 1<<k, `MemWData` = byte replicated ×4, load takes lane k.
  - Half: `MemBe` = 0011 if addr[1] = 0, else 1100; `MemWData` = half replicated ×2; load takes the lower or upper half.
  - Word: `MemBe` = 1111, data passed through unchanged.
- `MemAck` outside WAIT is ignored.
- A store never modifies `ReadDataFromMem_MEM` except loading 0.

## Timing
- Reset values: FSM IDLE; `MemReq`, `MemWe`, `BusErr_MEM` = 0; `MemAddr`, `MemWData`, `ReadDataFromMem_MEM` = 0; `MemBe` = 0000.
- Latency with a zero-wait memory (ack in the first WAIT cycle): op seen in cycle 0, `MemReq` high in cycle 1, DONE in cycle 2. Total 3 cycles, with `Stall_MEM` high in cycles 0–1.
- Each extra wait state adds one cycle.
- Bus handshake rule: once asserted, `MemReq` stays high with stable address and data until the edge on which `MemAck` is sampled.
- Reset asserted mid-WAIT: `MemReq` drops immediately (asynchronous) and the transaction is abandoned. The bus must tolerate the drop.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When the counter reaches `TIMEOUT_CYCLES` with no ack: drop `MemReq`, pulse `BusErr_MEM` for one cycle, load `ReadDataFromMem_MEM` with 0, go to DONE.
  - An ack on the same cycle as the timeout wins.
- `MEM_TIMEOUT_EN` not defined:
  - No counter is built; WAIT lasts indefinitely.
  - `BusErr_MEM` is constant 0.

## Test plan
- Word load, addr 0x0000_0010, `MemRData` = 0x1234_5678, ack on the first WAIT cycle → `MemAddr` = 0x10, `MemBe` = 1111, `Stall_MEM` high for 2 cycles, `ReadDataFromMem_MEM` = 0x1234_5678 in DONE.
- Signed byte load, addr 0x13, `MemRData` = 0x80FF_0102 → `MemBe` = 1000, result 0xFFFF_FF80. Same with `MemSignExt_MEM` = 0 → result 0x0000_0080.
- Half store, addr 0x22, data 0x0000_BEEF, ack after 3 wait cycles → `MemWe` = 1, `MemBe` = 1100, `MemWData` = 0xBEEF_BEEF held for 4 WAIT cycles, `Stall_MEM` high for 5 cycles.
- Word load at addr 0x0000_0006 → `MisalignExc_MEM` pulses, `MemReq` never rises, `Stall_MEM` = 0, result 0.
- `Reset` pulsed mid-WAIT → `MemReq` = 0 and FSM in IDLE immediately. A late `MemAck` afterwards leaves `ReadDataFromMem_MEM` = 0.
- With `MEM_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 4, no ack → `BusErr_MEM` pulses after 4 WAIT cycles, then DONE with result 0.
